// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation sequencer and its LSU mux.
// Holds the mont_mul operand-select codes, the word width and the FSM state encoding.
package mont_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SEL_B   = 2'd0;
    localparam logic [1:0] SEL_N   = 2'd1;
    localparam logic [1:0] SEL_A   = 2'd2;
    localparam logic [1:0] SEL_RES = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_EXP  = 3'd1,
        ST_SQ      = 3'd2,
        ST_GAP_SQ  = 3'd3,
        ST_MUL     = 3'd4,
        ST_GAP_MUL = 3'd5,
        ST_ADV     = 3'd6,
        ST_FIN     = 3'd7
    } state_e;

endpackage

// File: rtl/mont_lsu_mux.sv
// Combinational owner select for the single LSU port plus mont_mul base-address decode.
// Operand B is the accumulator while squaring and x while multiplying.
module mont_lsu_mux
    import mont_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic              mm_own,
    input  logic              is_mul,
    input  logic [1:0]        mm_sel,
    input  logic [AW-1:0]     x_addr,
    input  logic [AW-1:0]     n_addr,
    input  logic [AW-1:0]     acc_addr,
    input  logic              mm_ren,
    input  logic              mm_wen,
    input  logic [AW-1:0]     mm_addr_off,
    input  logic [WORD_W-1:0] mm_wdata,
    output logic              mm_lsu_done,
    output logic [WORD_W-1:0] mm_rdata,
    input  logic              ctl_ren,
    input  logic [AW-1:0]     ctl_addr,
    output logic              lsu_ren,
    output logic              lsu_wen,
    output logic [AW-1:0]     lsu_addr,
    output logic [WORD_W-1:0] lsu_wdata,
    input  logic [WORD_W-1:0] lsu_rdata,
    input  logic              lsu_done
);

    logic [AW-1:0] base;

    always_comb begin
        base = acc_addr;
        case (mm_sel)
            SEL_B:   base = is_mul ? x_addr : acc_addr;
            SEL_N:   base = n_addr;
            default: base = acc_addr;
        endcase
    end

    always_comb begin
        lsu_ren     = ctl_ren;
        lsu_wen     = 1'b0;
        lsu_addr    = ctl_addr;
        lsu_wdata   = '0;
        mm_lsu_done = 1'b0;
        mm_rdata    = '0;
        if (mm_own) begin
            lsu_ren     = mm_ren;
            lsu_wen     = mm_wen;
            lsu_addr    = base + mm_addr_off;
            lsu_wdata   = mm_wdata;
            mm_lsu_done = lsu_done;
            mm_rdata    = lsu_rdata;
        end
    end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mont_mul and owning the LSU port.
// Every exponent bit is squared (no leading-zero skip); set bits add one multiply by x.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int EXP_WORDS = 8,
    parameter int AW        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     exp_addr,
    input  logic [AW-1:0]     x_addr,
    input  logic [AW-1:0]     n_addr,
    input  logic [AW-1:0]     acc_addr,
    output logic              busy,
    output logic              done,
    output logic              mm_start,
    input  logic              mm_done,
    input  logic [1:0]        mm_sel,
    input  logic              mm_ren,
    input  logic              mm_wen,
    input  logic [AW-1:0]     mm_addr_off,
    input  logic [WORD_W-1:0] mm_wdata,
    output logic              mm_lsu_done,
    output logic [WORD_W-1:0] mm_rdata,
    output logic              lsu_ren,
    output logic              lsu_wen,
    output logic [AW-1:0]     lsu_addr,
    output logic [WORD_W-1:0] lsu_wdata,
    input  logic [WORD_W-1:0] lsu_rdata,
    input  logic              lsu_done
);

    localparam int WIDX_W = (EXP_WORDS > 1) ? $clog2(EXP_WORDS) : 1;

    state_e              state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [4:0]          bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ctl_ren;
    logic [AW-1:0]       ctl_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            widx_q    <= '0;
            bit_idx_q <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            bit_idx_q <= bit_idx_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        bit_idx_d = bit_idx_q;
        word_d    = word_q;
        busy      = 1'b1;
        done      = 1'b0;
        mm_start  = 1'b0;
        ctl_ren   = 1'b0;
        ctl_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    widx_d    = WIDX_W'(EXP_WORDS - 1);
                    bit_idx_d = 5'd31;
                    state_d   = ST_LD_EXP;
                end
            end
            ST_LD_EXP: begin
                ctl_ren  = 1'b1;
                ctl_addr = exp_addr + (AW'(widx_q) << 2);
                if (lsu_done) begin
                    word_d  = lsu_rdata;
                    state_d = ST_SQ;
                end
            end
            ST_SQ: begin
                mm_start = 1'b1;
                if (mm_done) state_d = ST_GAP_SQ;
            end
            // The exponent word is shifted left, so the current bit is always the MSB.
            ST_GAP_SQ:  state_d = word_q[WORD_W-1] ? ST_MUL : ST_ADV;
            ST_MUL: begin
                mm_start = 1'b1;
                if (mm_done) state_d = ST_GAP_MUL;
            end
            ST_GAP_MUL: state_d = ST_ADV;
            ST_ADV: begin
                word_d = word_q << 1;
                if (bit_idx_q != 5'd0) begin
                    bit_idx_d = bit_idx_q - 5'd1;
                    state_d   = ST_SQ;
                end else if (widx_q != '0) begin
                    widx_d    = widx_q - 1'b1;
                    bit_idx_d = 5'd31;
                    state_d   = ST_LD_EXP;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    mont_lsu_mux #(
        .AW(AW)
    ) u_lsu_mux (
        .mm_own      ((state_q == ST_SQ) || (state_q == ST_MUL)),
        .is_mul      (state_q == ST_MUL),
        .mm_sel      (mm_sel),
        .x_addr      (x_addr),
        .n_addr      (n_addr),
        .acc_addr    (acc_addr),
        .mm_ren      (mm_ren),
        .mm_wen      (mm_wen),
        .mm_addr_off (mm_addr_off),
        .mm_wdata    (mm_wdata),
        .mm_lsu_done (mm_lsu_done),
        .mm_rdata    (mm_rdata),
        .ctl_ren     (ctl_ren),
        .ctl_addr    (ctl_addr),
        .lsu_ren     (lsu_ren),
        .lsu_wen     (lsu_wen),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_rdata   (lsu_rdata),
        .lsu_done    (lsu_done)
    );

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: word-sized Montgomery multiplier model, handshaking memory,
// traffic monitor and directed exponent runs checked against plain modular exponentiation.
module tb_mont_exp_ctrl;

    localparam logic [31:0] EXP_A = 32'h100;
    localparam logic [31:0] X_A   = 32'h200;
    localparam logic [31:0] N_A   = 32'h300;
    localparam logic [31:0] ACC_A = 32'h400;
    localparam logic [31:0] OFF   = 32'h4;
    localparam int          ACC_W = 257;          // (ACC_A + OFF) >> 2
    localparam logic [31:0] NMOD  = 32'h7123_4567;
    localparam logic [31:0] XVAL  = 32'h0BAD_CAFE;

    localparam logic [2:0] S_IDLE = 3'd0, S_A = 3'd1, S_B = 3'd2, S_N = 3'd3, S_W = 3'd4, S_D = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, mm_start, mm_lsu_done;
    logic [31:0] mm_rdata;
    logic        lsu_ren, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        inj_lsu = 1'b0, inj_mm = 1'b0;
    logic        clr = 1'b0;
    logic        pl_we = 1'b0;
    logic [31:0] pl_addr = '0, pl_data = '0;

    logic [2:0]  ss;
    logic [31:0] ra, rb, rn;
    logic        mm_ren, mm_wen;
    logic [1:0]  mm_sel;
    logic [31:0] mm_wdata;

    logic [31:0] mem [0:511];
    int          n_rise, n_done, n_sq, n_mul, n_bad, n_ops, n_exp, done_ops;
    logic        op_kind [0:511];
    logic [31:0] exp_addr_log [0:15];
    int          exp_sq_log [0:15];
    logic        mm_start_prev;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.EXP_WORDS(8), .AW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .exp_addr    (EXP_A),
        .x_addr      (X_A),
        .n_addr      (N_A),
        .acc_addr    (ACC_A),
        .busy        (busy),
        .done        (done),
        .mm_start    (mm_start),
        .mm_done     ((ss == S_D) | inj_mm),
        .mm_sel      (mm_sel),
        .mm_ren      (mm_ren),
        .mm_wen      (mm_wen),
        .mm_addr_off (OFF),
        .mm_wdata    (mm_wdata),
        .mm_lsu_done (mm_lsu_done),
        .mm_rdata    (mm_rdata),
        .lsu_ren     (lsu_ren),
        .lsu_wen     (lsu_wen),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_rdata   (mem_rdata),
        .lsu_done    (mem_done | inj_lsu)
    );

    // a * b * 2^-32 mod n, bit-serial; a, b < n < 2^31.
    function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        logic [63:0] u;
        u = '0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) u = u + {32'd0, b};
            if (u[0]) u = u + {32'd0, n};
            u = u >> 1;
        end
        if (u >= {32'd0, n}) u = u - {32'd0, n};
        return u[31:0];
    endfunction

    function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        p = p % {32'd0, n};
        return p[31:0];
    endfunction

    function automatic logic [31:0] modexp(input logic [31:0] x, input logic [255:0] e, input logic [31:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 255; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, x, n);
        end
        return r;
    endfunction

    // mont_mul model: reads A, B, N at base+OFF, writes the product to Result, then pulses done.
    always_comb begin
        mm_ren   = (ss == S_A) || (ss == S_B) || (ss == S_N);
        mm_wen   = (ss == S_W);
        mm_sel   = 2'd3;
        case (ss)
            S_A:     mm_sel = 2'd2;
            S_B:     mm_sel = 2'd0;
            S_N:     mm_sel = 2'd1;
            default: mm_sel = 2'd3;
        endcase
        mm_wdata = mont(ra, rb, rn);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss <= S_IDLE;
            ra <= '0;
            rb <= '0;
            rn <= '0;
        end else begin
            case (ss)
                S_IDLE: if (mm_start) ss <= S_A;
                S_A:    if (mm_lsu_done) begin ra <= mm_rdata; ss <= S_B; end
                S_B:    if (mm_lsu_done) begin rb <= mm_rdata; ss <= S_N; end
                S_N:    if (mm_lsu_done) begin rn <= mm_rdata; ss <= S_W; end
                S_W:    if (mm_lsu_done) ss <= S_D;
                default: ss <= S_IDLE;
            endcase
        end
    end

    // Memory: acknowledges a held request one cycle after it appears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_done <= (lsu_ren | lsu_wen) && !mem_done;
            if (pl_we) begin
                mem[pl_addr[10:2]] <= pl_data;
            end else if ((lsu_ren | lsu_wen) && !mem_done) begin
                if (lsu_wen) mem[lsu_addr[10:2]] <= lsu_wdata;
                mem_rdata <= mem[lsu_addr[10:2]];
            end
        end
    end

    always @(posedge clk) begin
        mm_start_prev <= mm_start;
        if (clr) begin
            n_rise <= 0; n_done <= 0; n_sq <= 0; n_mul <= 0;
            n_bad <= 0; n_ops <= 0; n_exp <= 0; done_ops <= -1;
        end else begin
            if (mm_start && !mm_start_prev) n_rise <= n_rise + 1;
            if (done) begin n_done <= n_done + 1; done_ops <= n_ops; end
            if (ss == S_A && mm_lsu_done && lsu_addr != ACC_A + OFF) n_bad <= n_bad + 1;
            if (ss == S_B && mm_lsu_done) begin
                if (lsu_addr == ACC_A + OFF) begin
                    n_sq <= n_sq + 1;
                    if (n_ops < 512) op_kind[n_ops] <= 1'b0;
                end else if (lsu_addr == X_A + OFF) begin
                    n_mul <= n_mul + 1;
                    if (n_ops < 512) op_kind[n_ops] <= 1'b1;
                end else begin
                    n_bad <= n_bad + 1;
                end
            end
            if (ss == S_N && mm_lsu_done && lsu_addr != N_A + OFF) n_bad <= n_bad + 1;
            if (ss == S_W && mm_lsu_done) begin
                if (lsu_addr != ACC_A + OFF) n_bad <= n_bad + 1;
                n_ops <= n_ops + 1;
            end
            if (ss == S_IDLE && lsu_ren && (mem_done | inj_lsu) && n_exp < 16) begin
                exp_addr_log[n_exp] <= lsu_addr;
                exp_sq_log[n_exp]   <= n_sq;
                n_exp <= n_exp + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    // Preloads operands, starts one exponentiation and returns acc converted out of Montgomery form.
    task automatic run_exp(input string name, input logic [255:0] e, input bit poke_start,
                           input bit wait_end, output logic [31:0] res);
        bit ok;
        for (int w = 0; w < 8; w++) mem_write(EXP_A + 32'(4 * w), e[32 * w +: 32]);
        mem_write(X_A + OFF, 32'(({XVAL, 32'd0}) % {32'd0, NMOD}));
        mem_write(N_A + OFF, NMOD);
        mem_write(ACC_A + OFF, 32'(64'h1_0000_0000 % {32'd0, NMOD}));
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        if (poke_start) begin
            repeat (300) @(posedge clk);
            #1 start = 1'b1;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
        end
        res = '0;
        if (wait_end) begin
            wait_done(20000, ok);
            check({name, "_done_seen"}, 64'(ok), 64'd1);
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
            check({name, "_done_one_cycle"}, 64'(done), 64'd0);
            res = mont(mem[ACC_W], 32'd1, NMOD);
            $display("run %s: acc=%08h result=%08h sq=%0d mul=%0d", name, mem[ACC_W], res, n_sq, n_mul);
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] rmod;
        logic [255:0] e;
        int          order_err;
        bit          ok;

        rmod = 32'(64'h1_0000_0000 % {32'd0, NMOD});

        #1;
        check("reset_ctrl_outs", 64'({busy, done, mm_start, lsu_ren, lsu_wen, mm_lsu_done}), 64'd0);
        check("reset_lsu_addr", 64'(lsu_addr), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray acknowledgements while idle must not start anything.
        inj_lsu = 1'b1; inj_mm = 1'b1;
        @(posedge clk); #1;
        inj_lsu = 1'b0; inj_mm = 1'b0;
        @(posedge clk); #1;
        check("idle_stray_acks", 64'({busy, mm_start, lsu_ren}), 64'd0);

        // Only the top exponent bit set, plus a start poke while busy.
        e = '0; e[255] = 1'b1;
        run_exp("msb", e, 1'b1, 1'b1, res);
        check("msb_result", 64'(res), 64'(modexp(XVAL, e, NMOD)));
        check("msb_rises", 64'(n_rise), 64'd257);
        check("msb_squares", 64'(n_sq), 64'd256);
        check("msb_muls", 64'(n_mul), 64'd1);
        check("msb_bad_addr", 64'(n_bad), 64'd0);
        check("msb_done_count", 64'(n_done), 64'd1);
        check("msb_done_after_last", 64'(done_ops), 64'd257);
        order_err = 0;
        for (int i = 0; i < 257; i++) if (op_kind[i] !== (i == 1)) order_err++;
        check("msb_op_order", 64'(order_err), 64'd0);
        check("msb_exp_reads", 64'(n_exp), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("msb_exp_addr%0d", k), 64'(exp_addr_log[k]), 64'(EXP_A + 32'(28 - 4 * k)));
            check($sformatf("msb_exp_before_sq%0d", k), 64'(exp_sq_log[k]), 64'(32 * k));
        end

        // Zero exponent: acc stays at R mod N.
        run_exp("zero", 256'd0, 1'b0, 1'b1, res);
        check("zero_acc", 64'(mem[ACC_W]), 64'(rmod));
        check("zero_result", 64'(res), 64'd1);
        check("zero_squares", 64'(n_sq), 64'd256);
        check("zero_muls", 64'(n_mul), 64'd0);

        // e = 65537 against the golden model.
        e = 256'h10001;
        run_exp("f4", e, 1'b0, 1'b1, res);
        check("f4_result", 64'(res), 64'(modexp(XVAL, e, NMOD)));
        check("f4_squares", 64'(n_sq), 64'd256);
        check("f4_muls", 64'(n_mul), 64'd2);
        check("f4_bad_addr", 64'(n_bad), 64'd0);

        // Reset in the middle of the first multiply, then a clean restart.
        run_exp("rst", e, 1'b0, 1'b0, res);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            if (n_mul >= 1) begin ok = 1'b1; break; end
        end
        check("rst_reached_mul", 64'(ok), 64'd1);
        check("rst_in_mul_state", 64'(mm_start), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl_outs", 64'({busy, done, mm_start, lsu_ren, lsu_wen, mm_lsu_done}), 64'd0);
        check("rst_mid_lsu_addr", 64'(lsu_addr), 64'd0);
        check("rst_no_stale_done", 64'(n_done), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_exp("restart", e, 1'b0, 1'b1, res);
        check("restart_result", 64'(res), 64'(modexp(XVAL, e, NMOD)));
        check("restart_done_count", 64'(n_done), 64'd1);
        check("restart_muls", 64'(n_mul), 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
